// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions for the receive path: default baud divisor, frame
// data width, line idle level, the receiver state encoding, and a helper that
// derives the half-bit sample offset from the bit period.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 217;
    localparam int   DATA_BITS            = 8;
    localparam logic LINE_IDLE            = 1'b1;

    // Receiver states. Values 5..7 are unused and recover to RX_WAIT_IDLE.
    typedef enum logic [2:0] {
        RX_WAIT_IDLE = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START_BIT = 3'd2,
        RX_DATA_BITS = 3'd3,
        RX_STOP_BIT  = 3'd4
    } rx_state_e;

    // Cycles from the start-bit detection to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous inputs. Both stages reset to
// RST_VAL so the synchronised output presents a known level while in reset.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input bits
//   q_o    : synchronised output bits (two clock latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Each bit is synchronised independently; no multi-bit coherence implied.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                meta_q[gi] <= RST_VAL;
                sync_q[gi] <= RST_VAL;
            end else begin
                meta_q[gi] <= d_i[gi];
                sync_q[gi] <= meta_q[gi];
            end
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Synchronises the RX pin, detects the start bit, samples
// each bit at its middle and presents the received byte with a one-cycle
// valid strobe. A bad (low) stop bit gives a one-cycle framing-error strobe
// and leaves the last good byte in place.
// Ports:
//   i_Clk          : system clock
//   i_Rst_L        : asynchronous active-low reset
//   i_RX_Serial    : raw asynchronous UART line, idle high
//   o_RX_Byte      : last correctly received byte
//   o_RX_DV        : one-cycle strobe, new byte on o_RX_Byte
//   o_RX_Frame_Err : one-cycle strobe, stop bit sampled low
//   o_RX_Busy      : high while a frame is being received
// CLKS_PER_BIT must be at least 4 and match the transmitter.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 rx_sync;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q,  byte_d;
    logic                 dv_q,    dv_d;
    logic                 fe_q,    fe_d;
    logic                 busy_q,  busy_d;

    // Synchroniser resets to the idle level so reset never looks like a
    // start bit.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (LINE_IDLE)
    ) u_sync (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_L),
        .d_i    (i_RX_Serial),
        .q_o    (rx_sync)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= RX_WAIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            // Holds off after reset or a framing error until the line is
            // seen idle, so a stuck-low line cannot retrigger frames.
            RX_WAIT_IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (rx_sync == LINE_IDLE) begin
                    state_d = RX_IDLE;
                end
            end

            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_sync != LINE_IDLE) begin
                    state_d = RX_START_BIT;
                    busy_d  = 1'b1;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            RX_START_BIT: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_sync != LINE_IDLE) begin
                        state_d = RX_DATA_BITS;
                    end else begin
                        state_d = RX_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            // From mid start bit, every full bit period lands mid data bit.
            RX_DATA_BITS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP_BIT;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            // Leaving here mid stop bit re-arms early enough to catch a
            // back-to-back start edge.
            RX_STOP_BIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_WAIT_IDLE;
                    busy_d  = 1'b0;
                    if (rx_sync == LINE_IDLE) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RX_WAIT_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_RX_Byte      = byte_q;
    assign o_RX_DV        = dv_q;
    assign o_RX_Frame_Err = fe_q;
    assign o_RX_Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at 16 clocks per bit. The line is driven by a
// behavioural transmitter task; strobes are collected by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_byte;
    logic       dv;
    logic       fe;
    logic       busy;

    int cyc       = 0;
    int fall_cyc  = 0;
    int errors    = 0;
    int checks    = 0;
    int dv_cnt    = 0;
    int fe_cnt    = 0;
    int overlap   = 0;
    int dv_cyc    = 0;
    logic [7:0] dv_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_RX_Serial    (rx),
        .o_RX_Byte      (rx_byte),
        .o_RX_DV        (dv),
        .o_RX_Frame_Err (fe),
        .o_RX_Busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (dv) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            dv_q.push_back(rx_byte);
        end
        if (fe) fe_cnt = fe_cnt + 1;
        if (dv && fe) overlap = overlap + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural transmitter; called at a negedge, returns at a negedge
    // with the line idle.
    task automatic send_frame(input logic [7:0] b, input int cpb,
                              input logic stop, input int stop_len);
        rx       = 1'b0;
        fall_cyc = cyc + 1;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    function automatic logic [31:0] got_byte(input int i);
        if (i < dv_q.size()) return 32'(dv_q[i]);
        return 32'hdead;
    endfunction

    logic [7:0] b2b_vec [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
    logic [7:0] prev_byte;
    int base_dv;
    int base_fe;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(rx_byte), 32'h0);
        check("rst_dv",   32'(dv),      32'h0);
        check("rst_fe",   32'(fe),      32'h0);
        check("rst_busy", 32'(busy),    32'h0);
        rst_n = 1'b1;
        idle(5);

        // Single frame, latency from start-bit fall to strobe
        send_frame(8'hA5, CPB, 1'b1, CPB);
        idle(4);
        check("a5_dv_count", 32'(dv_cnt),       32'd1);
        check("a5_byte",     32'(rx_byte),      32'hA5);
        check("a5_latency",  32'(dv_cyc - fall_cyc), 32'd154);
        check("a5_fe_count", 32'(fe_cnt),       32'd0);

        // Back-to-back frames
        base_dv = dv_cnt;
        dv_q.delete();
        for (int i = 0; i < 4; i++) send_frame(b2b_vec[i], CPB, 1'b1, CPB);
        idle(20);
        check("b2b_count", 32'(dv_cnt - base_dv), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("b2b_byte%0d", i), got_byte(i), 32'(b2b_vec[i]));

        // Glitch: 5 cycles low
        base_dv = dv_cnt;
        base_fe = fe_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        idle(40);
        check("glitch_no_dv", 32'(dv_cnt - base_dv), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt - base_fe), 32'd0);

        // Framing error with line held low, then a good frame
        base_dv   = dv_cnt;
        base_fe   = fe_cnt;
        prev_byte = rx_byte;
        send_frame(8'h3C, CPB, 1'b0, 40);
        idle(20);
        check("fe_count",     32'(fe_cnt - base_fe), 32'd1);
        check("fe_no_dv",     32'(dv_cnt - base_dv), 32'd0);
        check("fe_byte_hold", 32'(rx_byte),          32'(prev_byte));
        check("fe_busy",      32'(busy),             32'h0);
        send_frame(8'h3C, CPB, 1'b1, CPB);
        idle(4);
        check("fe_recover_dv",   32'(dv_cnt - base_dv), 32'd1);
        check("fe_recover_byte", 32'(rx_byte),          32'h3C);

        // Reset during data bit 3 of a frame whose remaining bits are high
        base_dv = dv_cnt;
        base_fe = fe_cnt;
        fork
            send_frame(8'hF8, CPB, 1'b1, CPB);
            begin
                repeat (72) @(negedge clk);
                check("mid_busy_before", 32'(busy), 32'h1);
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_byte", 32'(rx_byte), 32'h0);
                check("mid_rst_busy", 32'(busy),    32'h0);
                check("mid_rst_dv",   32'(dv),      32'h0);
                repeat (10) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(20);
        check("mid_no_dv", 32'(dv_cnt - base_dv), 32'd0);
        check("mid_no_fe", 32'(fe_cnt - base_fe), 32'd0);
        send_frame(8'h7E, CPB, 1'b1, CPB);
        idle(4);
        check("mid_next_dv",   32'(dv_cnt - base_dv), 32'd1);
        check("mid_next_byte", 32'(rx_byte),          32'h7E);

        // Baud skew: transmitter at 15 and 17 clocks per bit
        base_dv = dv_cnt;
        send_frame(8'hC3, 15, 1'b1, 15);
        idle(20);
        check("skew15_dv",   32'(dv_cnt - base_dv), 32'd1);
        check("skew15_byte", 32'(rx_byte),          32'hC3);
        send_frame(8'h00, CPB, 1'b1, CPB);
        idle(4);
        base_dv = dv_cnt;
        send_frame(8'hC3, 17, 1'b1, 17);
        idle(20);
        check("skew17_dv",   32'(dv_cnt - base_dv), 32'd1);
        check("skew17_byte", 32'(rx_byte),          32'hC3);

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
